// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage forwarding selects, load-use and MDU occupancy stalls.
// Keeps its own EX/MEM copy of destination info taken from the ID/EX controls.
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             dmdu_start,
    input  logic             dmdu_read,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       edestReg,
    output logic             wpcir,
    output logic             bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int MW = $clog2(MDU_LAT + 1);

    logic             mwreg_q, mm2reg_q;
    logic [4:0]       mdest_q;
    logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lu_stall, mdu_stall, stall;

    // Register 0 is excluded up front so no EX/MEM match can select a forward
    assign fwda = !duse_rs || drs == 5'd0 ? 2'b00 :
                  ewreg && !em2reg && edestReg == drs ? 2'b01 :
                  mwreg_q && mdest_q == drs ? (mm2reg_q ? 2'b11 : 2'b10) : 2'b00;
    assign fwdb = !duse_rt || drt == 5'd0 ? 2'b00 :
                  ewreg && !em2reg && edestReg == drt ? 2'b01 :
                  mwreg_q && mdest_q == drt ? (mm2reg_q ? 2'b11 : 2'b10) : 2'b00;

    assign lu_stall  = ewreg && em2reg && edestReg != 5'd0 &&
                       ((duse_rs && drs == edestReg) || (duse_rt && drt == edestReg));
    assign mdu_busy  = mdu_cnt_q != '0;
    assign mdu_stall = mdu_busy && (dmdu_start || dmdu_read);
    assign stall     = lu_stall || mdu_stall;
    assign wpcir     = !stall;
    assign bubble    = stall;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        mdu_cnt_d   = mdu_busy ? mdu_cnt_q - MW'(1) :
                      dmdu_start && !stall ? MW'(MDU_LAT) : '0;
        stall_cnt_d = stall && !(&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mwreg_q     <= 1'b0;
            mm2reg_q    <= 1'b0;
            mdest_q     <= '0;
            mdu_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mwreg_q     <= ewreg;
            mm2reg_q    <= em2reg;
            mdest_q     <= edestReg;
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of forwarding, stalls, MDU occupancy and
// stall counter saturation (second instance with a 4-bit counter).
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  drs, drt, edestReg;
    logic        duse_rs, duse_rt, dmdu_start, dmdu_read, ewreg, em2reg;
    logic        wpcir, bubble, mdu_busy;
    logic [1:0]  fwda, fwdb;
    logic [15:0] stall_cnt;
    logic        s_wpcir, s_bubble, s_busy;
    logic [1:0]  s_fwda, s_fwdb;
    logic [3:0]  s_cnt;
    int          checks = 0;
    int          errors = 0;
    int          busy_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .dmdu_start(dmdu_start), .dmdu_read(dmdu_read), .ewreg(ewreg), .em2reg(em2reg),
        .edestReg(edestReg), .wpcir(wpcir), .bubble(bubble), .fwda(fwda), .fwdb(fwdb),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .dmdu_start(dmdu_start), .dmdu_read(dmdu_read), .ewreg(ewreg), .em2reg(em2reg),
        .edestReg(edestReg), .wpcir(s_wpcir), .bubble(s_bubble), .fwda(s_fwda), .fwdb(s_fwdb),
        .mdu_busy(s_busy), .stall_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drs = 0; drt = 0; duse_rs = 0; duse_rt = 0; dmdu_start = 0; dmdu_read = 0;
        ewreg = 0; em2reg = 0; edestReg = 0;
    endtask

    task automatic ex(input logic w, input logic m, input logic [4:0] d);
        ewreg = w; em2reg = m; edestReg = d;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        #1;
        chk("rst_fwda", fwda, 2'b00);
        chk("rst_fwdb", fwdb, 2'b00);
        chk("rst_busy", mdu_busy, 1'b0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_wpcir", wpcir, 1'b1);
        chk("rst_bubble", bubble, 1'b0);
        chk("rst_sat_cnt", s_cnt, 4'd0);
        rst = 0;
        tick();

        ex(1, 1, 8); drs = 8; duse_rs = 1;
        #1;
        chk("lu_wpcir", wpcir, 1'b0);
        chk("lu_bubble", bubble, 1'b1);
        chk("lu_fwda", fwda, 2'b00);
        tick();
        ex(0, 0, 0);
        #1;
        chk("lu_clear_wpcir", wpcir, 1'b1);
        chk("lu_mem_fwda", fwda, 2'b11);
        chk("lu_cnt", stall_cnt, 16'd1);
        tick();

        idle(); ex(1, 1, 10); drt = 10; duse_rt = 1;
        #1;
        chk("lu_rt_wpcir", wpcir, 1'b0);
        tick();
        ex(0, 0, 0);
        #1;
        chk("lu_rt_fwdb", fwdb, 2'b11);
        chk("lu_rt_fwda", fwda, 2'b00);
        chk("lu_rt_cnt", stall_cnt, 16'd2);
        tick();

        idle(); ex(1, 0, 9);
        tick();
        drs = 9; drt = 9; duse_rs = 1; duse_rt = 1;
        #1;
        chk("pri_ex_fwda", fwda, 2'b01);
        chk("pri_ex_fwdb", fwdb, 2'b01);
        chk("pri_ex_wpcir", wpcir, 1'b1);
        tick();
        ex(0, 0, 0);
        #1;
        chk("pri_mem_fwda", fwda, 2'b10);
        chk("pri_mem_fwdb", fwdb, 2'b10);
        duse_rs = 0;
        #1;
        chk("nouse_fwda", fwda, 2'b00);
        tick();

        idle(); ex(1, 1, 0); drs = 0; duse_rs = 1;
        #1;
        chk("zero_fwda", fwda, 2'b00);
        chk("zero_wpcir", wpcir, 1'b1);
        chk("zero_bubble", bubble, 1'b0);
        tick();
        ex(0, 0, 0);
        #1;
        chk("zero_mem_fwda", fwda, 2'b00);
        chk("zero_cnt", stall_cnt, 16'd2);
        tick();

        idle(); dmdu_start = 1;
        #1;
        chk("mdu_t_busy", mdu_busy, 1'b0);
        chk("mdu_t_wpcir", wpcir, 1'b1);
        tick();
        dmdu_start = 0;
        #1;
        chk("mdu_t1_busy", mdu_busy, 1'b1);
        chk("mdu_t1_wpcir", wpcir, 1'b1);
        tick();
        dmdu_read = 1;
        for (int i = 2; i <= 4; i++) begin
            #1;
            chk($sformatf("mdu_t%0d_busy", i), mdu_busy, 1'b1);
            chk($sformatf("mdu_t%0d_wpcir", i), wpcir, 1'b0);
            tick();
        end
        #1;
        chk("mdu_t5_busy", mdu_busy, 1'b0);
        chk("mdu_t5_wpcir", wpcir, 1'b1);
        chk("mdu_t5_cnt", stall_cnt, 16'd5);

        dmdu_read = 0; dmdu_start = 1;
        busy_cycles = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("b2b_stall%0d_wpcir", i), wpcir, 1'b0);
            busy_cycles += int'(mdu_busy);
            tick();
        end
        #1;
        chk("b2b_gap_busy", mdu_busy, 1'b0);
        chk("b2b_accept_wpcir", wpcir, 1'b1);
        tick();
        dmdu_start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            busy_cycles += int'(mdu_busy);
            tick();
        end
        #1;
        chk("b2b_busy_cycles", busy_cycles, 8);
        chk("b2b_end_busy", mdu_busy, 1'b0);
        chk("b2b_cnt", stall_cnt, 16'd9);

        dmdu_start = 1;
        tick();
        dmdu_start = 0;
        tick();
        rst = 1;
        #1;
        chk("rstmdu_t2_busy", mdu_busy, 1'b1);
        tick();
        rst = 0;
        #1;
        chk("rstmdu_t3_busy", mdu_busy, 1'b0);
        chk("rstmdu_t3_cnt", stall_cnt, 16'd0);
        chk("rstmdu_t3_sat", s_cnt, 4'd0);
        tick();
        #1;
        chk("rstmdu_t4_busy", mdu_busy, 1'b0);

        idle(); ex(1, 1, 8); drs = 8; duse_rs = 1;
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("sat_15", s_cnt, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk("sat_20", s_cnt, 4'd15);
        chk("sat_main_20", stall_cnt, 16'd20);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
